// File: rtl/pcpi_mul_initiator.sv
`default_nettype none
// ============================================================================
// Module     : pcpi_mul_initiator
// Description: Issues RV32M multiply ops to a PCPI coprocessor with a
//              wait-aware timeout; divide ops are rejected with an error.
// Revision   : 1.0 - initial release
// ============================================================================
module pcpi_mul_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_funct3,
    input  logic [31:0] cmd_rs1,
    input  logic [31:0] cmd_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic [15:0] last_latency,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_CYCLES);

    state_t      state_q,     state_d;
    logic [31:0] rs1_q,       rs1_d;
    logic [31:0] rs2_q,       rs2_d;
    logic [31:0] insn_q,      insn_d;
    logic [15:0] cnt_q,       cnt_d;
    logic        wait_seen_q, wait_seen_d;
    logic [31:0] rsp_data_q,  rsp_data_d;
    logic        rsp_error_q, rsp_error_d;
    logic [15:0] last_lat_q,  last_lat_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            insn_q      <= '0;
            cnt_q       <= '0;
            wait_seen_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            last_lat_q  <= '0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            insn_q      <= insn_d;
            cnt_q       <= cnt_d;
            wait_seen_q <= wait_seen_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            last_lat_q  <= last_lat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        insn_d      = insn_q;
        cnt_d       = cnt_q;
        wait_seen_d = wait_seen_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        last_lat_d  = last_lat_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rs1_d       = cmd_rs1;
                    rs2_d       = cmd_rs2;
                    insn_d      = {7'b0000001, 5'd2, 5'd1, cmd_funct3, 5'd10, 7'b0110011};
                    cnt_d       = 16'd1;
                    wait_seen_d = 1'b0;
                    if (cmd_funct3[2]) begin
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (pcpi_wait) begin
                    wait_seen_d = 1'b1;
                end
                // A completing ready wins over a timeout landing on the same edge.
                if (pcpi_ready) begin
                    rsp_data_d  = pcpi_wr ? pcpi_rd : 32'd0;
                    rsp_error_d = ~pcpi_wr;
                    last_lat_d  = cnt_q;
                    state_d     = ST_RESP;
                end else if (!(wait_seen_q || pcpi_wait) && (cnt_q >= C_TIMEOUT)) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign pcpi_valid   = (state_q == ST_ISSUE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_error    = rsp_error_q;
    assign last_latency = last_lat_q;
    assign pcpi_insn    = insn_q;
    assign pcpi_rs1     = rs1_q;
    assign pcpi_rs2     = rs2_q;

endmodule
`default_nettype wire

// File: tb/tb_pcpi_mul_initiator.sv
`default_nettype none
// ============================================================================
// Module     : tb_pcpi_mul_initiator
// Description: Directed self-checking bench with a scripted PCPI responder.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pcpi_mul_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_funct3 = '0;
    logic [31:0] cmd_rs1 = '0;
    logic [31:0] cmd_rs2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [15:0] last_latency;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        pcpi_wait = 1'b0;
    logic        pcpi_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    pcpi_mul_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct3(cmd_funct3),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .last_latency(last_latency),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mulref(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        case (f3[1:0])
            2'b00:   p = sa * sb;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = {32'd0, a} * ub;
        endcase
        return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Present a command once the block is ready; returns just after the accepting edge.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        for (int g = 0; g < 50 && !cmd_ready; g++) @(negedge clk);
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_funct3 = f3; cmd_rs1 = a; cmd_rs2 = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Responder: ready on ISSUE cycle rdy_at (0 = never); ends at the first non-ISSUE negedge.
    task automatic respond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input int rdy_at, input logic wt, input logic wr, input int exp_issue);
        int n;
        bit done;
        n = 0;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (!pcpi_valid) begin
                done = 1;
            end else begin
                n++;
                chk("pcpi_insn", pcpi_insn, {7'b0000001, 5'd2, 5'd1, f3, 5'd10, 7'b0110011});
                chk("pcpi_rs1", pcpi_rs1, a);
                chk("pcpi_rs2", pcpi_rs2, b);
                pcpi_wait  = wt;
                pcpi_ready = (n == rdy_at);
                pcpi_wr    = wr;
                pcpi_rd    = mulref(f3, a, b);
            end
        end
        pcpi_ready = 1'b0; pcpi_wait = 1'b0; pcpi_wr = 1'b0;
        chk("issue_done", done, 1);
        chk("issue_cycles", n, exp_issue);
    endtask

    task automatic collect(input logic [31:0] ed, input logic ee, input logic [15:0] el);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_error", rsp_error, ee);
        chk("last_latency", last_latency, el);
        chk("resp_cmd_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        logic [31:0] held;
        repeat (3) @(negedge clk);
        chk("rst_pcpi_valid", pcpi_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_insn", pcpi_insn, 0);
        chk("rst_latency", last_latency, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // MUL 3*7 with wait, ready on 4th ISSUE cycle
        send(3'b000, 32'd3, 32'd7);
        chk("mul_insn_const", pcpi_insn, 32'h02208533);
        respond(3'b000, 32'd3, 32'd7, 4, 1'b1, 1'b1, 4);
        collect(32'd21, 1'b0, 16'd4);

        send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        respond(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b0, 1'b1, 1);
        collect(32'hFFFFFFFE, 1'b0, 16'd1);

        send(3'b001, -32'sd10, -32'sd4);
        respond(3'b001, -32'sd10, -32'sd4, 3, 1'b0, 1'b1, 3);
        collect(32'd0, 1'b0, 16'd3);

        send(3'b010, -32'sd10, 32'd4);
        respond(3'b010, -32'sd10, 32'd4, 2, 1'b0, 1'b1, 2);
        collect(32'hFFFFFFFF, 1'b0, 16'd2);

        // Silent responder: timeout after 16 cycles, latency untouched
        send(3'b000, 32'd5, 32'd5);
        respond(3'b000, 32'd5, 32'd5, 0, 1'b0, 1'b1, 16);
        collect(32'd0, 1'b1, 16'd2);

        // Ready on the timeout cycle wins
        send(3'b000, 32'd6, 32'd6);
        respond(3'b000, 32'd6, 32'd6, 16, 1'b0, 1'b1, 16);
        collect(32'd36, 1'b0, 16'd16);

        // Wait held: no abort, ready after 40 cycles
        send(3'b000, 32'd12, 32'd11);
        respond(3'b000, 32'd12, 32'd11, 40, 1'b1, 1'b1, 40);
        collect(32'd132, 1'b0, 16'd40);

        // Divide op rejected without touching PCPI
        send(3'b100, 32'd9, 32'd3);
        respond(3'b100, 32'd9, 32'd3, 1, 1'b0, 1'b1, 0);
        collect(32'd0, 1'b1, 16'd40);

        // Ready with wr=0 is an error
        send(3'b000, 32'd2, 32'd2);
        respond(3'b000, 32'd2, 32'd2, 2, 1'b0, 1'b0, 2);
        collect(32'd0, 1'b1, 16'd2);

        // Back-pressure with a second command pending; PCPI noise during RESP
        send(3'b000, 32'd100, 32'd200);
        respond(3'b000, 32'd100, 32'd200, 1, 1'b0, 1'b1, 1);
        held = rsp_data;
        chk("bp_first_data", held, 32'd20000);
        cmd_valid = 1'b1; cmd_funct3 = 3'b000; cmd_rs1 = 32'd7; cmd_rs2 = 32'd8;
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 32'd20000);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_pcpi_valid", pcpi_valid, 0);
        end
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_ready", cmd_ready, 1);
        chk("bp_not_issued", pcpi_valid, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        respond(3'b000, 32'd7, 32'd8, 2, 1'b0, 1'b1, 2);
        collect(32'd56, 1'b0, 16'd2);

        // Asynchronous reset mid-ISSUE
        send(3'b000, 32'd9, 32'd9);
        @(negedge clk);
        chk("mid_issue_valid", pcpi_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_pcpi_valid", pcpi_valid, 0);
        chk("arst_insn", pcpi_insn, 0);
        chk("arst_rs1", pcpi_rs1, 0);
        chk("arst_latency", last_latency, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("arst_cmd_ready", cmd_ready, 1);
        send(3'b000, 32'd5, 32'd6);
        respond(3'b000, 32'd5, 32'd6, 1, 1'b0, 1'b1, 1);
        collect(32'd30, 1'b0, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
